ringbuf_rdxfer: RTL

RINGBUF_RDXFER -- requirements
Module: ringbuf_rdxfer

---
 rtl/ringbuf_rdxfer_if.sv | 29 ++
 rtl/ringbuf_rdxfer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ringbuf_rdxfer_if.sv
// Event readout bus: request/ack, ring-buffer read port, downstream sample stream.
// Latency: n/a (signal bundle only).
// Backpressure: DOUT_VLD/DOUT_RDY handshake on the sample stream; EVT_REQ is held until EVT_ACK.
interface ringbuf_rdxfer_if #(
    parameter int RB_AW = 12
);
    logic             EVT_REQ;
    logic [RB_AW-1:0] EVT_ADDR;
    logic             EVT_ACK;
    logic             RB_RDEN;
    logic [RB_AW-1:0] RB_RDADDR;
    logic [11:0]      RB_DOUT;
    logic [11:0]      DOUT;
    logic             DOUT_VLD;
    logic             DOUT_RDY;
    logic             DOUT_LAST;

    // Readout engine side
    modport master (
        input  EVT_REQ, EVT_ADDR, RB_DOUT, DOUT_RDY,
        output EVT_ACK, RB_RDEN, RB_RDADDR, DOUT, DOUT_VLD, DOUT_LAST
    );

    // Requester / ring-buffer memory / downstream consumer side
    modport slave (
        output EVT_REQ, EVT_ADDR, RB_DOUT, DOUT_RDY,
        input  EVT_ACK, RB_RDEN, RB_RDADDR, DOUT, DOUT_VLD, DOUT_LAST
    );
endinterface

// File: rtl/ringbuf_rdxfer.sv
// Reads one event (NSAMP*16 words) out of the sample ring buffer starting at EVT_ADDR and streams it downstream.
// Latency: first RB_RDEN 1 cycle after EVT_ACK, first DOUT_VLD 2 cycles after that; then 1 word/cycle.
// Backpressure: DOUT_RDY low stalls reads via a 2-entry output buffer credit; reads also stall while RPTR == WPTR.
module ringbuf_rdxfer #(
    parameter int RB_AW = 12,
    parameter int NSAMP = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WREN,
    output logic             BUSY,
    output logic [RB_AW-1:0] WPTR,
    ringbuf_rdxfer_if.master bus
);
    localparam int EVLEN = NSAMP * 16;
    localparam int CW = $clog2(EVLEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(EVLEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic [RB_AW-1:0] wptr;
    logic [RB_AW-1:0] rptr;
    logic [CW-1:0]    issue_cnt;
    logic             ack_q;

    // Read pipeline: rd_d1 marks the cycle RB_DOUT carries the word of the previous read
    logic             rd_d1;
    logic             rd_last_d1;

    // Output buffer: entry = {last, data}
    logic [12:0]      fifo_mem [2];
    logic             wr_idx;
    logic             rd_idx;
    logic [1:0]       fifo_cnt;
    logic [12:0]      head;

    logic             push;
    logic             pop;
    logic             fifo_vld;
    logic [2:0]       credit_use;
    logic             credit_ok;
    logic             issue;
    logic             issue_last;

    assign head     = fifo_mem[rd_idx];
    assign fifo_vld = (fifo_cnt != 2'd0);
    assign push     = rd_d1;
    assign pop      = fifo_vld && bus.DOUT_RDY && !RST;

    // Words that will occupy the buffer once everything already issued has landed.
    // A word leaving this cycle frees its slot in time for a read issued this cycle,
    // which lands two edges from now; that is what allows one word per cycle.
    assign credit_use = {1'b0, fifo_cnt} + {2'b00, rd_d1} - {2'b00, pop};
    assign credit_ok  = (credit_use < 3'd2);

    // The ACK cycle is skipped so the first read follows the acknowledge by one cycle.
    // Empty check uses the registered write pointer, so a same-cycle write does not count yet.
    assign issue      = (state == READ) && !ack_q && (rptr != wptr) && credit_ok && !RST;
    assign issue_last = issue && (issue_cnt == LAST_IDX);

    // Write pointer follows every write strobe regardless of readout state
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr <= '0;
        end else if (WREN) begin
            wptr <= wptr + 1'b1;
        end
    end

    // Readout FSM: accept request, issue EVLEN reads, wait for the tagged last word to leave
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            rptr      <= '0;
            issue_cnt <= '0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.EVT_REQ) begin
                        state     <= READ;
                        ack_q     <= 1'b1;
                        rptr      <= bus.EVT_ADDR;
                        issue_cnt <= '0;
                    end
                end
                READ: begin
                    if (issue) begin
                        rptr      <= rptr + 1'b1;
                        issue_cnt <= issue_cnt + 1'b1;
                        if (issue_cnt == LAST_IDX) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head[12]) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Track which cycle the ring buffer returns data for, plus its last-word tag;
    // reset drops any read still in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_d1      <= 1'b0;
            rd_last_d1 <= 1'b0;
        end else begin
            rd_d1      <= issue;
            rd_last_d1 <= issue_last;
        end
    end

    // Two-entry output buffer; the credit check guarantees a push never meets a full buffer
    always_ff @(posedge CLK) begin
        if (RST) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_idx      <= 1'b0;
            rd_idx      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_idx] <= {rd_last_d1, bus.RB_DOUT};
                wr_idx           <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Outputs are forced quiet while reset is held so nothing leaks before the clearing edge
    assign bus.EVT_ACK   = ack_q && !RST;
    assign bus.RB_RDEN   = issue;
    assign bus.RB_RDADDR = RST ? '0 : rptr;
    assign bus.DOUT      = RST ? 12'd0 : head[11:0];
    assign bus.DOUT_VLD  = fifo_vld && !RST;
    assign bus.DOUT_LAST = fifo_vld && head[12] && !RST;
    assign BUSY          = (state != IDLE) && !RST;
    assign WPTR          = RST ? '0 : wptr;

    // Buffer occupancy stays within its two entries
    a_fifo_bound : assert property (@(posedge CLK) disable iff (RST) fifo_cnt <= 2'd2);
    a_no_overflow : assert property (@(posedge CLK) disable iff (RST)
                                     !(push && !pop && fifo_cnt == 2'd2));
endmodule
